// File: rtl/ir_transmitter.sv
// IR remote-control transmitter: sends a fixed-format packet of carrier bursts and gaps
// encoding four direction bits, once per PACKET_PERIOD, with carrier timing chosen per car.
package ir_pkg;
  typedef struct packed {
    logic [10:0] half;
    logic [7:0]  start_sz;
    logic [7:0]  gap_sz;
    logic [7:0]  asrt_sz;
    logic [7:0]  dsrt_sz;
  } car_cfg_t;
endpackage

module car_select
  import ir_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic [1:0] i_car,
  output car_cfg_t   o_cfg
);
  // Half-period is the rounded CLK count for each car's carrier (36 / 40 / 37.5 kHz).
  // At 100 MHz this gives 1389 / 1250 / 1333.
  localparam logic [10:0] HP_36K  = 11'((CLK_FREQ + 36_000) / 72_000);
  localparam logic [10:0] HP_40K  = 11'((CLK_FREQ + 40_000) / 80_000);
  localparam logic [10:0] HP_375K = 11'((CLK_FREQ + 37_500) / 75_000);

  always_comb begin
    case (i_car)
      2'd0:    o_cfg = '{HP_36K,  8'd191, 8'd25, 8'd47, 8'd22};
      2'd1:    o_cfg = '{HP_40K,  8'd88,  8'd40, 8'd22, 8'd11};
      2'd2:    o_cfg = '{HP_375K, 8'd88,  8'd40, 8'd44, 8'd22};
      default: o_cfg = '{HP_36K,  8'd192, 8'd24, 8'd48, 8'd24};
    endcase
  end
endmodule

module ir_transmitter
  import ir_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int PACKET_PERIOD = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COMMAND,
  input  logic [1:0] CAR_SWITCHES,
  output logic       IR_LED,
  output logic [1:0] LEDS
);
  typedef enum logic [3:0] {
    IDLE, START, GAP_S, RIGHT, GAP_R, LEFT, GAP_L, BACK, GAP_B, FWD, GAP_F
  } state_t;

  localparam logic [23:0] TMAX = 24'(PACKET_PERIOD - 1);

  state_t      r_state;
  logic [23:0] r_timer;
  logic [10:0] r_per_cnt;
  logic [10:0] r_half_cnt;
  logic        r_first_half;
  logic        r_led;
  logic [3:0]  r_cmd;
  car_cfg_t    r_cfg;

  car_cfg_t    w_cfg;
  logic [7:0]  w_size;
  logic        w_burst;
  state_t      w_next;

  car_select #(.CLK_FREQ(CLK_FREQ)) u_car_select (.i_car(CAR_SWITCHES), .o_cfg(w_cfg));

  assign LEDS   = CAR_SWITCHES;
  assign IR_LED = r_led;

  function automatic logic is_burst(input state_t s);
    return (s == START) || (s == RIGHT) || (s == LEFT) || (s == BACK) || (s == FWD);
  endfunction

  // Segment length and successor for the current state, from the packet-latched settings.
  always_comb begin
    w_size  = r_cfg.gap_sz;
    w_next  = IDLE;
    w_burst = is_burst(r_state);
    case (r_state)
      START: begin w_size = r_cfg.start_sz;                          w_next = GAP_S; end
      GAP_S: w_next = RIGHT;
      RIGHT: begin w_size = r_cmd[1] ? r_cfg.asrt_sz : r_cfg.dsrt_sz; w_next = GAP_R; end
      GAP_R: w_next = LEFT;
      LEFT:  begin w_size = r_cmd[0] ? r_cfg.asrt_sz : r_cfg.dsrt_sz; w_next = GAP_L; end
      GAP_L: w_next = BACK;
      BACK:  begin w_size = r_cmd[2] ? r_cfg.asrt_sz : r_cfg.dsrt_sz; w_next = GAP_B; end
      GAP_B: w_next = FWD;
      FWD:   begin w_size = r_cmd[3] ? r_cfg.asrt_sz : r_cfg.dsrt_sz; w_next = GAP_F; end
      GAP_F: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_per_cnt    <= '0;
      r_half_cnt   <= '0;
      r_first_half <= 1'b0;
      r_led        <= 1'b0;
      r_cmd        <= '0;
      r_cfg        <= '0;
    end else begin
      r_timer <= (r_timer == TMAX) ? '0 : r_timer + 24'd1;
      if (r_state == IDLE) begin
        // Timer ticks outside IDLE are simply dropped: no queued restart.
        if (r_timer == '0) begin
          r_state      <= START;
          r_cmd        <= COMMAND;
          r_cfg        <= w_cfg;
          r_per_cnt    <= '0;
          r_half_cnt   <= '0;
          r_first_half <= 1'b1;
          r_led        <= 1'b1;
        end
      end else if (r_half_cnt == r_cfg.half - 11'd1) begin
        r_half_cnt <= '0;
        if (r_first_half) begin
          r_first_half <= 1'b0;
          r_led        <= 1'b0;
        end else if (r_per_cnt == 11'(w_size) - 11'd1) begin
          r_state      <= w_next;
          r_per_cnt    <= '0;
          r_first_half <= 1'b1;
          r_led        <= is_burst(w_next);
        end else begin
          r_per_cnt    <= r_per_cnt + 11'd1;
          r_first_half <= 1'b1;
          r_led        <= w_burst;
        end
      end else begin
        r_half_cnt <= r_half_cnt + 11'd1;
      end
    end
  end
endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter at a scaled clock, comparing IR_LED cycle by cycle
// against a segment-list model of the packet and counting carrier edges per packet.
module tb_ir_transmitter;
  localparam int CLK_FREQ = 400_000;
  localparam int PP       = 6500;

  // Half periods at 400 kHz: round(400000 / (2 * {36k, 40k, 37.5k, 36k})).
  int hp_t[4] = '{6, 5, 5, 6};
  int st_t[4] = '{191, 88, 88, 192};
  int gp_t[4] = '{25, 40, 40, 24};
  int as_t[4] = '{47, 22, 44, 48};
  int ds_t[4] = '{22, 11, 22, 24};

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] COMMAND = 4'd0;
  logic [1:0] CAR_SWITCHES = 2'd0;
  wire        IR_LED;
  wire  [1:0] LEDS;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ir_transmitter #(.CLK_FREQ(CLK_FREQ), .PACKET_PERIOD(PP)) dut (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .CAR_SWITCHES(CAR_SWITCHES),
    .IR_LED(IR_LED), .LEDS(LEDS)
  );

  function automatic int dir_sz(input int car, input logic [3:0] cmd, input int b);
    return cmd[b] ? as_t[car] : ds_t[car];
  endfunction

  function automatic int model_edges(input int car, input logic [3:0] cmd);
    return st_t[car] + dir_sz(car, cmd, 0) + dir_sz(car, cmd, 1) + dir_sz(car, cmd, 2) + dir_sz(car, cmd, 3);
  endfunction

  // Expected IR_LED u cycles after packet start: walk START,GAP,R,GAP,L,GAP,B,GAP,F,GAP.
  function automatic logic model_level(input int u, input int car, input logic [3:0] cmd);
    int seg[10];
    int hp, p, ph;
    seg = '{st_t[car], gp_t[car], dir_sz(car, cmd, 1), gp_t[car], dir_sz(car, cmd, 0),
            gp_t[car], dir_sz(car, cmd, 2), gp_t[car], dir_sz(car, cmd, 3), gp_t[car]};
    hp = hp_t[car];
    p  = u / (2 * hp);
    ph = u % (2 * hp);
    for (int i = 0; i < 10; i++) begin
      if (p < seg[i]) return (i % 2 == 0) && (ph < hp);
      p -= seg[i];
    end
    return 1'b0;
  endfunction

  task automatic run_packets(input string name, input int car_a, input logic [3:0] cmd_a,
                             input int npk, input int chg_t, input int car_b, input logic [3:0] cmd_b);
    int m_car, edges, wmiss, first_miss;
    logic [3:0] m_cmd;
    logic prev, exp_l;
    RESET = 1'b1; CAR_SWITCHES = car_a[1:0]; COMMAND = cmd_a;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    prev = 1'b0; edges = 0; wmiss = 0; first_miss = -1; m_car = 0; m_cmd = 4'd0;
    for (int t = 0; t < npk * PP; t++) begin
      if (t == chg_t) begin CAR_SWITCHES = car_b[1:0]; COMMAND = cmd_b; end
      if (t % PP == 0) begin
        m_car = int'(CAR_SWITCHES); m_cmd = COMMAND;
        edges = 0; wmiss = 0; first_miss = -1;
      end
      @(negedge CLK);
      exp_l = model_level(t % PP, m_car, m_cmd);
      if (IR_LED !== exp_l) begin
        wmiss++;
        if (first_miss < 0) first_miss = t;
      end
      if (IR_LED === 1'b1 && prev === 1'b0) edges++;
      prev = IR_LED;
      if (t % PP == PP - 1) begin
        total++;
        if (edges !== model_edges(m_car, m_cmd)) begin
          bad++;
          $display("FAIL %s edges pkt%0d: got %0d want %0d", name, t / PP, edges, model_edges(m_car, m_cmd));
        end
        total++;
        if (wmiss !== 0) begin
          bad++;
          $display("FAIL %s waveform pkt%0d: %0d wrong cycles, first at t=%0d, want 0", name, t / PP, wmiss, first_miss);
        end
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int c = 0; c < 4; c++) begin
      CAR_SWITCHES = 2'(c); COMMAND = 4'(c * 5);
      @(negedge CLK);
      total++;
      if (IR_LED !== 1'b0) begin bad++; $display("FAIL reset_led car%0d: got %b want 0", c, IR_LED); end
      total++;
      if (LEDS !== 2'(c)) begin bad++; $display("FAIL reset_leds: got %0d want %0d", LEDS, c); end
    end
  endtask

  task automatic test_cars();
    for (int c = 0; c < 4; c++) run_packets($sformatf("car%0d_0101", c), c, 4'b0101, 1, -1, c, 4'b0101);
  endtask

  task automatic test_cmd_extremes();
    run_packets("car0_0000", 0, 4'b0000, 1, -1, 0, 4'b0000);
    run_packets("car0_1111", 0, 4'b1111, 1, -1, 0, 4'b1111);
  endtask

  task automatic test_midpacket_change();
    run_packets("midchange", 0, 4'b0101, 2, PP / 2, 0, 4'b1010);
  endtask

  task automatic test_random();
    int ca, cb, ct;
    logic [3:0] ma, mb;
    ca = int'($urandom_range(0, 3)); cb = int'($urandom_range(0, 3));
    ma = 4'($urandom_range(0, 15));  mb = 4'($urandom_range(0, 15));
    ct = int'($urandom_range(1, PP - 1));
    run_packets($sformatf("rand_c%0d_m%0h_to_c%0d_m%0h", ca, ma, cb, mb), ca, ma, 2, ct, cb, mb);
  endtask

  task automatic test_abort();
    RESET = 1'b1; CAR_SWITCHES = 2'd1; COMMAND = 4'b0101;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK); @(negedge CLK);
    total++;
    if (IR_LED !== 1'b1) begin bad++; $display("FAIL abort_pre: got %b want 1", IR_LED); end
    RESET = 1'b1;
    #1;
    total++;
    if (IR_LED !== 1'b0) begin bad++; $display("FAIL abort_immediate: got %b want 0", IR_LED); end
    @(negedge CLK);
    total++;
    if (IR_LED !== 1'b0) begin bad++; $display("FAIL abort_held: got %b want 0", IR_LED); end
    run_packets("after_abort", 1, 4'b0101, 1, -1, 1, 4'b0101);
  endtask

  initial begin
    test_reset();
    test_cars();
    test_cmd_extremes();
    test_midpacket_change();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ir_transmitter.md
IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the CLK frequency in Hz.
REQ-002 The block SHALL have parameter PACKET_PERIOD, default 10_000_000, meaning CLK cycles between packet starts (100 ms).
REQ-003 The block SHALL have port CLK, input, 1 bit, system clock.
REQ-004 The block SHALL have port RESET, input, 1 bit; reset is RESET, asynchronous, active-high; clock is CLK.
REQ-005 The block SHALL have port COMMAND, input, 4 bits: [0] left, [1] right, [2] backward, [3] forward.
REQ-006 The block SHALL have port CAR_SWITCHES, input, 2 bits, car select.
REQ-007 The block SHALL have port IR_LED, output, 1 bit, modulated IR drive.
REQ-008 The block SHALL have port LEDS, output, 2 bits, selected-car indicator.

Function
REQ-009 The block SHALL contain a combinational car_select sub-block mapping CAR_SWITCHES to a settings record {HALF_PERIOD, START_SIZE, GAP_SIZE, ASSERT_SIZE, DEASSERT_SIZE}, and SHALL drive LEDS = CAR_SWITCHES.
REQ-010 Settings SHALL be: 0 Blue {1389, 191, 25, 47, 22}; 1 Yellow {1250, 88, 40, 22, 11}; 2 Green {1333, 88, 40, 44, 22}; 3 Red {1389, 192, 24, 48, 24}. HALF_PERIOD is in CLK cycles; all sizes are in carrier periods.
REQ-011 A carrier period SHALL be 2*HALF_PERIOD CLK cycles: IR_LED high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
REQ-012 A burst of N SHALL produce exactly N IR_LED rising edges. IR_LED SHALL rise on the first cycle of the burst and SHALL be low at the end of the burst.
REQ-013 During a gap of N, IR_LED SHALL stay low for N carrier periods. IR_LED SHALL also be low in IDLE.
REQ-014 The packet sequence SHALL be: START(START_SIZE), GAP, RIGHT, GAP, LEFT, GAP, BACKWARD, GAP, FORWARD, GAP, then IDLE.
REQ-015 The size of each direction burst SHALL be ASSERT_SIZE if the corresponding COMMAND bit is 1, otherwise DEASSERT_SIZE.
REQ-016 The FSM states SHALL be IDLE, START, GAP_S, RIGHT, GAP_R, LEFT, GAP_L, BACK, GAP_B, FWD, GAP_F.
REQ-017 On each transition to a new state, the FSM SHALL reset its period counter and its half-period counter.
REQ-018 A free-running packet timer SHALL count 0 to PACKET_PERIOD-1 and wrap. Each time it reads 0, IDLE SHALL transition to START.
REQ-019 If the timer reaches 0 while a packet is still in progress, the tick SHALL be ignored; no restart and no queueing.
REQ-020 COMMAND and the car settings SHALL be registered on the IDLE-to-START transition and held constant for the whole packet. Changes mid-packet SHALL affect only the next packet.
REQ-021 The packet timer SHALL be 24 bits wide. Period and half-period counters SHALL be at least 11 bits wide and compare with equality against (value-1).

Reset
REQ-022 While RESET is high: FSM in IDLE, timer = 0, all counters = 0, latched command = 0, latched car = 0, IR_LED = 0.
REQ-023 The first packet SHALL start on the first CLK edge after RESET deasserts.
REQ-024 Asserting RESET mid-packet SHALL force IR_LED low immediately, abort the packet, and restart per REQ-023.
REQ-025 LEDS SHALL follow CAR_SWITCHES independent of RESET.

Verification
REQ-026 Reset, CAR_SWITCHES=0, COMMAND=0101, count IR_LED rising edges for 50 ms -> 191+47+22+47+22 = 329.
REQ-027 Repeat REQ-026 for CAR_SWITCHES=1, 2 and 3 -> 88+22+11+22+11 = 154; 88+44+22+44+22 = 220; 192+48+24+48+24 = 336.
REQ-028 Car 0, COMMAND=0000 -> 191+4*22 = 279 edges; COMMAND=1111 -> 191+4*47 = 379 edges.
REQ-029 Car 1: measure IR_LED high time = 12.5 us and period = 25 us; gap after START = 40 periods = 1 ms with IR_LED low.
REQ-030 Change COMMAND from 0101 to 1010 at 50 ms -> the packet at 100 ms still totals 329 edges on car 0, and the packet starts exactly 10,000,000 cycles after the first.
REQ-031 Assert RESET during a burst -> IR_LED low within the same cycle; after release the count restarts with a full START burst.
